// File: rtl/score_display_pkg.sv
// score_display_pkg
// Shared types and constants for the score display block:
//   state_t        conversion FSM states
//   SEG_BLANK/ZERO active-low segment patterns {g,f,e,d,c,b,a}
//   DIGIT_COUNT    decimal digits needed for a 16-bit score
//   dabble_adjust  the "+3 on nibbles >= 5" step of double-dabble
`timescale 1ns/1ps
package score_display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    localparam int SCORE_W     = 16;
    localparam int DIGIT_COUNT = 5;
    localparam int BCD_W       = 4 * DIGIT_COUNT;
    localparam int AN_W        = 8;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Pre-shift correction: any nibble that would exceed 9 after doubling
    // gets +3 so the carry lands in the next decimal digit.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] result;
        result = bcd;
        for (int i = 0; i < DIGIT_COUNT; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                result[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/score_display_if.sv
// score_display_if
// Bundles the score input and the display-side outputs.
//   score : 16-bit unsigned score (processor -> display block)
//   an    : 8 digit anodes, active-low
//   seg   : 7 segments {g,f,e,d,c,b,a}, active-low
//   dp    : decimal point, active-low (always off)
//   busy  : conversion in progress
// master = score producer / observer, slave = the display block.
`timescale 1ns/1ps
interface score_display_if;
    logic [15:0] score;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;

    modport master (
        output score,
        input  an,
        input  seg,
        input  dp,
        input  busy
    );

    modport slave (
        input  score,
        output an,
        output seg,
        output dp,
        output busy
    );
endinterface

// File: rtl/score_display_seg7_decode.sv
// seg7_decode
// Combinational BCD digit to seven-segment decoder.
//   bcd : 4-bit digit value
//   seg : segments {g,f,e,d,c,b,a}, active-low; codes 10..15 are blank
`timescale 1ns/1ps
module seg7_decode
    import score_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_ZERO;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// score_display
// Samples the 16-bit score periodically, converts it to five BCD digits
// with a one-bit-per-cycle double-dabble engine, and scans the digits onto
// a multiplexed 8-digit seven-segment display with leading-zero blanking.
// Ports:
//   clk   : board clock, all state on rising edge
//   reset : asynchronous, active-low
//   disp  : score_display_if.slave (score in; an, seg, dp, busy out)
`timescale 1ns/1ps
module score_display
    import score_display_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter int SAMPLE_DIV = 1666667,
    parameter int NUM_DIGITS = DIGIT_COUNT
)
(
    input  logic           clk,
    input  logic           reset,
    score_display_if.slave disp
);

    localparam int SAMPLE_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_DIV - 1);
    localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
    localparam logic [2:0]          IDX_LAST    = 3'(DIGIT_COUNT - 1);

    // ---------------- sample timing ----------------
    logic [SAMPLE_W-1:0] sample_cnt_reg;
    logic                sample_tick;
    logic                tick_reg;

    assign sample_tick = (sample_cnt_reg == SAMPLE_LAST);

    // tick_reg delays the tick by one edge so the capture happens on the
    // edge after the tick edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_cnt_reg <= '0;
            tick_reg       <= 1'b0;
        end else begin
            sample_cnt_reg <= sample_tick ? '0 : sample_cnt_reg + 1'b1;
            tick_reg       <= sample_tick;
        end
    end

    // ---------------- conversion FSM ----------------
    state_t                            state_reg, state_next;
    logic [SCORE_W-1:0]                shift_reg, shift_next;
    logic [BCD_W-1:0]                  bcd_reg, bcd_next;
    logic [3:0]                        bit_cnt_reg, bit_cnt_next;
    logic [DIGIT_COUNT-1:0][3:0]       disp_reg, disp_next;
    logic                              busy_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bcd_reg     <= '0;
            bit_cnt_reg <= '0;
            disp_reg    <= '0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bcd_reg     <= bcd_next;
            bit_cnt_reg <= bit_cnt_next;
            disp_reg    <= disp_next;
            // Held through the cycle in which the freshly loaded digits are
            // first visible, so busy covers capture edge through load edge.
            busy_reg    <= (state_next != IDLE) || (state_reg != IDLE);
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bcd_next     = bcd_reg;
        bit_cnt_next = bit_cnt_reg;
        disp_next    = disp_reg;
        case (state_reg)
            IDLE: begin
                // Ticks arriving outside IDLE are simply ignored.
                if (tick_reg) begin
                    shift_next   = disp.score;
                    bcd_next     = '0;
                    bit_cnt_next = '0;
                    state_next   = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_next, shift_next} = {dabble_adjust(bcd_reg), shift_reg} << 1;
                bit_cnt_next = bit_cnt_reg + 4'd1;
                if (bit_cnt_reg == 4'd15) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                disp_next  = bcd_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- digit decode and blanking ----------------
    // Decode from disp_next so a load on a scan edge shows the new value
    // on that same edge.
    logic [6:0]             dig_seg [DIGIT_COUNT];
    logic [DIGIT_COUNT-1:0] digit_blank;

    assign digit_blank[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < DIGIT_COUNT; gi++) begin : g_dec
            seg7_decode u_dec (
                .bcd (disp_next[gi]),
                .seg (dig_seg[gi])
            );
        end
        for (genvar gi = 1; gi < DIGIT_COUNT; gi++) begin : g_blank
            // Blank when this digit and every more-significant one is zero.
            assign digit_blank[gi] = ~|disp_next[DIGIT_COUNT-1:gi];
        end
    endgenerate

    // ---------------- scan ----------------
    logic [SCAN_W-1:0] scan_cnt_reg;
    logic              scan_wrap;
    logic [2:0]        digit_idx_reg, digit_idx_next;
    logic [AN_W-1:0]   an_reg, an_next;
    logic [6:0]        seg_reg, seg_next;

    assign scan_wrap = (scan_cnt_reg == SCAN_LAST);

    always_comb begin
        digit_idx_next = digit_idx_reg;
        if (scan_wrap) begin
            digit_idx_next = (digit_idx_reg == IDX_LAST) ? 3'd0 : digit_idx_reg + 3'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < AN_W; gi++) begin : g_an
            if (gi < NUM_DIGITS) begin : g_active
                assign an_next[gi] = (digit_idx_next != 3'(gi));
            end else begin : g_off
                assign an_next[gi] = 1'b1;
            end
        end
    endgenerate

    assign seg_next = digit_blank[digit_idx_next] ? SEG_BLANK : dig_seg[digit_idx_next];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt_reg  <= '0;
            digit_idx_reg <= '0;
            an_reg        <= 8'b1111_1110;
            seg_reg       <= SEG_ZERO;
        end else begin
            scan_cnt_reg  <= scan_wrap ? '0 : scan_cnt_reg + 1'b1;
            digit_idx_reg <= digit_idx_next;
            if (scan_wrap) begin
                an_reg  <= an_next;
                seg_reg <= seg_next;
            end
        end
    end

    assign disp.an   = an_reg;
    assign disp.seg  = seg_reg;
    assign disp.dp   = 1'b1;
    assign disp.busy = busy_reg;

endmodule

// File: tb/tb_score_display.sv
`timescale 1ns/1ps
module tb_score_display;

    localparam int SCAN_DIV   = 4;
    localparam int SAMPLE_DIV = 64;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    score_display_if disp_if ();

    score_display #(
        .SCAN_DIV   (SCAN_DIV),
        .SAMPLE_DIV (SAMPLE_DIV),
        .NUM_DIGITS (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .disp  (disp_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0]     score;
        logic [4:0][6:0] seg_exp;   // index k = digit k
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Waits for busy to rise, then counts negedges with busy high.
    // If change_at > 0, score is changed after that many busy cycles.
    task automatic wait_busy(input int change_at, input logic [15:0] new_score, output int len);
        int t;
        t   = 0;
        len = 0;
        while (disp_if.busy !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            timeout("busy_rise");
            return;
        end
        while (disp_if.busy === 1'b1 && len < 100) begin
            len++;
            if (len == change_at) disp_if.score = new_score;
            @(negedge clk);
        end
        if (len >= 100) timeout("busy_fall");
    endtask

    // Watches one and a bit scan frames and records the segments per digit.
    task automatic check_frame(input string tag, input logic [4:0][6:0] exp);
        logic [4:0][6:0] got;
        logic [7:0]      pat;
        bit              an_ok;
        bit              found;
        got   = '1;
        an_ok = 1'b1;
        repeat (5) @(negedge clk);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            found = 1'b0;
            for (int k = 0; k < 5; k++) begin
                pat = ~(8'd1 << k);
                if (disp_if.an === pat) begin
                    got[k] = disp_if.seg;
                    found  = 1'b1;
                end
            end
            if (!found || disp_if.dp !== 1'b1) an_ok = 1'b0;
        end
        check({tag, "_an_dp"}, 32'(an_ok), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("%s_digit%0d", tag, k), 32'(got[k]), 32'(exp[k]));
        end
        $display("frame %s: digits4..0 = %b %b %b %b %b", tag, got[4], got[3], got[2], got[1], got[0]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"},   32'(disp_if.an),   32'h0000_00FE);
        check({tag, "_seg"},  32'(disp_if.seg),  32'(S0));
        check({tag, "_dp"},   32'(disp_if.dp),   32'd1);
        check({tag, "_busy"}, 32'(disp_if.busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int t;

        vecs[0].score = 16'd0;     vecs[0].seg_exp = {SB, SB, SB, SB, S0};
        vecs[1].score = 16'd12345; vecs[1].seg_exp = {S1, S2, S3, S4, S5};
        vecs[2].score = 16'd65535; vecs[2].seg_exp = {S6, S5, S5, S3, S5};
        vecs[3].score = 16'd0;     vecs[3].seg_exp = {SB, SB, SB, SB, S0};
        vecs[4].score = 16'd100;   vecs[4].seg_exp = {SB, SB, S1, S0, S0};

        disp_if.score = 16'd0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_held");
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_release");
        $display("reset released, outputs at reset values");

        // Before any sample the zeroed digit registers show a single "0".
        check_frame("pre_sample", {SB, SB, SB, SB, S0});

        for (int i = 0; i < 5; i++) begin
            disp_if.score = vecs[i].score;
            wait_busy(0, 16'd0, len);
            check($sformatf("busy_len_v%0d", i), 32'(len), 32'd18);
            $display("vector %0d score=%0d busy_cycles=%0d", i, vecs[i].score, len);
            check_frame($sformatf("v%0d", i), vecs[i].seg_exp);
        end

        // Score changed mid-conversion: the in-flight result keeps 42.
        disp_if.score = 16'd42;
        wait_busy(5, 16'd999, len);
        check("busy_len_42", 32'(len), 32'd18);
        $display("score 42 converted while score changed to 999 in flight");
        check_frame("in_flight_42", {SB, SB, SB, S4, S2});
        wait_busy(0, 16'd0, len);
        check("busy_len_999", 32'(len), 32'd18);
        check_frame("next_999", {SB, SB, S9, S9, S9});

        // Reset in the middle of a conversion.
        disp_if.score = 16'd777;
        t = 0;
        while (disp_if.busy !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) timeout("busy_rise_777");
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_conv_reset");
        $display("reset asserted mid-conversion of 777");
        @(negedge clk);
        reset = 1'b1;
        check_frame("post_reset", {SB, SB, SB, SB, S0});
        wait_busy(0, 16'd0, len);
        check("busy_len_777", 32'(len), 32'd18);
        check_frame("after_reset_777", {SB, SB, S7, S7, S7});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
